input_buffer_bank: RTL and testbench

INPUT_BUFFER_BANK -- requirements
Module: input_buffer_bank

---
 rtl/input_buffer_bank.sv | 197 +++++++++++++++++++
 tb/tb_input_buffer_bank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_bank.sv
// Column FIFO bank fed row-major from a synchronous ROM: prefetches K+1 image rows, then refills one row per consumer request.
// Optional simulation checks are compiled in with INPUT_BUFFER_ASSERT_EN.
module input_buffer_bank #(
    parameter int BANK_WIDTH        = 64,
    parameter int INT_WIDTH         = 8,
    parameter int ROM_IMAGE_DEPTH_W = 10,
    parameter int FIFO_DEPTH        = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_async_i,
    input  logic                                  start_i,
    input  logic [31:0]                           cfg_img_w_i,
    input  logic [3:0]                            cfg_kernel_r_i,
    output logic [ROM_IMAGE_DEPTH_W-1:0]          rom_addr_o,
    output logic                                  rom_rd_en_o,
    input  logic [INT_WIDTH-1:0]                  rom_data_i,
    input  logic [BANK_WIDTH-1:0]                 pop_i,
    output logic [BANK_WIDTH-1:0][INT_WIDTH-1:0]  data_out_o,
    input  logic                                  pre_wave_done_i,
    output logic                                  ib_ready_o,
    output logic [1:0]                            dbg_state_o
);

    localparam int COL_W = (BANK_WIDTH > 1) ? $clog2(BANK_WIDTH) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREFETCH = 2'd1,
        S_READY    = 2'd2,
        S_REFILL   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_w;
    logic [31:0]            r_rows;
    logic [31:0]            r_target;
    logic [ROM_IMAGE_DEPTH_W-1:0] r_addr;
    logic                   r_rd_en;
    logic [COL_W-1:0]       r_col;
    logic                   r_pending;
    logic                   r_ready;
    logic                   r_wr_en;
    logic [COL_W-1:0]       r_wr_col;
    logic                   r_wr_last;

    logic w_start;
    logic w_row_end;
    logic w_fetch_last;

    assign w_start      = start_i && ((r_state == S_IDLE) || (r_state == S_READY));
    assign w_row_end    = ({{(32-COL_W){1'b0}}, r_col} == (r_w - 32'd1));
    assign w_fetch_last = w_row_end && ((r_rows + 32'd1) == r_target);

    assign rom_addr_o  = r_addr;
    assign rom_rd_en_o = r_rd_en;
    assign ib_ready_o  = r_ready;
    assign dbg_state_o = r_state;

    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            r_state   <= S_IDLE;
            r_w       <= '0;
            r_rows    <= '0;
            r_target  <= '0;
            r_addr    <= '0;
            r_rd_en   <= 1'b0;
            r_col     <= '0;
            r_pending <= 1'b0;
            r_ready   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_col  <= '0;
            r_wr_last <= 1'b0;
        end else begin
            // Write side lags the read strobe by one cycle to meet the ROM data.
            r_wr_en   <= r_rd_en;
            r_wr_col  <= r_col;
            r_wr_last <= r_rd_en && w_fetch_last && (r_state == S_PREFETCH);
            if (r_wr_last) begin
                r_ready <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_READY: begin
                    if (w_start) begin
                        r_state   <= S_PREFETCH;
                        r_w       <= cfg_img_w_i;
                        r_target  <= {28'd0, cfg_kernel_r_i} + 32'd1;
                        r_rows    <= '0;
                        r_addr    <= '0;
                        r_col     <= '0;
                        r_rd_en   <= 1'b1;
                        r_pending <= 1'b0;
                        r_ready   <= 1'b0;
                    end else if ((r_state == S_READY) && (r_pending || pre_wave_done_i)) begin
                        r_pending <= 1'b0;
                        if (r_rows < r_w) begin
                            r_state  <= S_REFILL;
                            r_target <= r_rows + 32'd1;
                            r_rd_en  <= 1'b1;
                        end
                    end
                end
                S_PREFETCH, S_REFILL: begin
                    if (pre_wave_done_i) begin
                        r_pending <= 1'b1;
                    end
                    if (r_rd_en) begin
                        r_addr <= r_addr + 1'b1;
                        if (w_row_end) begin
                            r_col  <= '0;
                            r_rows <= r_rows + 32'd1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (w_fetch_last) begin
                            r_rd_en <= 1'b0;
                            r_state <= S_READY;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < BANK_WIDTH; c++) begin : g_col
        logic [INT_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]     r_wp;
        logic [PTR_W-1:0]     r_rp;
        logic [CNT_W-1:0]     r_cnt;
        logic                 w_push;
        logic                 w_pop;

        // A full FIFO drops the incoming pixel; an empty FIFO ignores pop.
        assign w_push = r_wr_en && (r_wr_col == COL_W'(c)) && (r_cnt != CNT_W'(FIFO_DEPTH));
        assign w_pop  = pop_i[c] && (r_cnt != '0);

        always_ff @(posedge clk_i or posedge rst_async_i) begin
            if (rst_async_i) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else if (w_start) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_wp <= r_wp + 1'b1;
                end
                if (w_pop) begin
                    r_rp <= r_rp + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_push && !w_start) begin
                r_mem[r_wp] <= rom_data_i;
            end
        end

        assign data_out_o[c] = (r_cnt != '0) ? r_mem[r_rp] : '0;

`ifdef INPUT_BUFFER_ASSERT_EN
        always @(posedge clk_i) begin
            if (!rst_async_i && !w_start) begin
                assert (!(r_wr_en && (r_wr_col == COL_W'(c)) && (r_cnt == CNT_W'(FIFO_DEPTH))))
                    else $error("input_buffer_bank: push to full FIFO column %0d", c);
                assert (!(pop_i[c] && (r_cnt == '0)))
                    else $error("input_buffer_bank: pop of empty FIFO column %0d", c);
            end
        end
`endif
    end

`ifdef INPUT_BUFFER_ASSERT_EN
    always @(posedge clk_i) begin
        if (!rst_async_i && w_start) begin
            assert (cfg_img_w_i <= 32'(BANK_WIDTH))
                else $error("input_buffer_bank: image width %0d exceeds bank width", cfg_img_w_i);
            assert (({28'd0, cfg_kernel_r_i} + 32'd1) <= 32'(FIFO_DEPTH))
                else $error("input_buffer_bank: K+1 rows exceed FIFO depth");
        end
    end
`else
    // Configuration and FIFO misuse checks are compiled out.
`endif

endmodule

// File: tb/tb_input_buffer_bank.sv
// Directed and randomized bench for input_buffer_bank with a per-column queue reference model.
module tb_input_buffer_bank;

    localparam int BW = 64;
    localparam int IW = 8;
    localparam int AW = 10;
    localparam int FD = 16;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [31:0]           cfg_w;
    logic [3:0]            cfg_k;
    logic [AW-1:0]         rom_addr;
    logic                  rom_rd_en;
    logic [IW-1:0]         rom_data;
    logic [BW-1:0]         pop;
    logic [BW-1:0][IW-1:0] data_out;
    logic                  pre_wave;
    logic                  ib_ready;
    logic [1:0]            dbg_state;

    logic [IW-1:0] rom_mem [1<<AW];
    logic [IW-1:0] exp_q [BW][$];

    int n_checks;
    int n_err;
    int m_w;
    int m_rows;
    int m_addr;

    input_buffer_bank #(
        .BANK_WIDTH(BW), .INT_WIDTH(IW), .ROM_IMAGE_DEPTH_W(AW), .FIFO_DEPTH(FD)
    ) dut (
        .clk_i(clk), .rst_async_i(rst), .start_i(start),
        .cfg_img_w_i(cfg_w), .cfg_kernel_r_i(cfg_k),
        .rom_addr_o(rom_addr), .rom_rd_en_o(rom_rd_en), .rom_data_i(rom_data),
        .pop_i(pop), .data_out_o(data_out),
        .pre_wave_done_i(pre_wave), .ib_ready_o(ib_ready), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom_mem[rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [IW-1:0] exp_head(input int c);
        if (exp_q[c].size() > 0) return exp_q[c][0];
        return '0;
    endfunction

    task automatic check_heads(input string tag);
        for (int c = 0; c < BW; c++)
            check($sformatf("%s_col%0d", tag, c), 32'(data_out[c]), 32'(exp_head(c)));
    endtask

    task automatic model_clear();
        for (int c = 0; c < BW; c++) exp_q[c].delete();
        m_rows = 0;
        m_addr = 0;
    endtask

    // Appends whole image rows to the column queues, as the refill rules dictate.
    task automatic model_rows(input int n);
        for (int i = 0; i < n; i++) begin
            if (m_rows < m_w) begin
                for (int c = 0; c < m_w; c++) exp_q[c].push_back(rom_mem[m_rows*m_w + c]);
                m_rows++;
                m_addr += m_w;
            end
        end
    endtask

    task automatic model_start(input int w, input int k);
        model_clear();
        m_w = w;
        model_rows(k + 1);
    endtask

    task automatic model_pop(input logic [BW-1:0] m);
        for (int c = 0; c < BW; c++)
            if (m[c] && exp_q[c].size() > 0) void'(exp_q[c].pop_front());
    endtask

    task automatic pop_cols(input logic [BW-1:0] m, input string tag);
        pop = m;
        model_pop(m);
        @(negedge clk);
        pop = '0;
        check_heads(tag);
    endtask

    // Drives start/pre_wave/pop at chosen cycle offsets and counts read strobes until the bus goes quiet.
    task automatic run_fetch(input int budget, input int s0, input int s1,
                             input int p0, input int p1, input int p2,
                             input int pp, input logic [BW-1:0] pmask,
                             output int reads, output int maxrun);
        int idle;
        int run;
        bit seen;
        idle = 0; run = 0; seen = 0; reads = 0; maxrun = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            start    = (cyc == s0) || (cyc == s1);
            pre_wave = (cyc == p0) || (cyc == p1) || (cyc == p2);
            pop      = (cyc == pp) ? pmask : '0;
            @(negedge clk);
            if (rom_rd_en) begin
                reads++; run++; seen = 1; idle = 0;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
                if (seen) idle++;
            end
            if (seen && idle >= 4) break;
        end
        start = 1'b0; pre_wave = 1'b0; pop = '0;
    endtask

    initial begin
        int reads;
        int maxrun;
        int wr;
        int kr;
        int pp;
        logic [BW-1:0] pm;
        logic [BW-1:0] nm;
        bit full;

        n_checks = 0; n_err = 0; m_w = 0;
        for (int i = 0; i < (1<<AW); i++) rom_mem[i] = IW'($urandom);
        rst = 1'b1; start = 1'b0; cfg_w = '0; cfg_k = '0; pop = '0; pre_wave = 1'b0;
        model_clear();

        repeat (2) @(negedge clk);
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_rd_en", 32'(rom_rd_en), 0);
        check("rst_ready", 32'(ib_ready), 0);
        check("rst_state", 32'(dbg_state), 0);
        check_heads("rst");
        rst = 1'b0;
        @(negedge clk);

        // W=28 K=5 prefetch, with a second start mid-prefetch that must be ignored
        cfg_w = 28; cfg_k = 5;
        model_start(28, 5);
        run_fetch(1000, 0, 20, -1, -1, -1, -1, '0, reads, maxrun);
        check("pf_reads", reads, 168);
        check("pf_run", maxrun, 168);
        check("pf_addr", 32'(rom_addr), 168);
        check("pf_rd_en", 32'(rom_rd_en), 0);
        check("pf_ready", 32'(ib_ready), 1);
        check("pf_state", 32'(dbg_state), 2);
        check("pf_head0", 32'(data_out[0]), 32'(rom_mem[0]));
        check("pf_head1", 32'(data_out[1]), 32'(rom_mem[1]));
        check_heads("pf");
        pop_cols(64'h3, "pop01");
        check("pop_head0", 32'(data_out[0]), 32'(rom_mem[28]));

        run_fetch(200, -1, -1, 0, -1, -1, -1, '0, reads, maxrun);
        model_rows(1);
        check("rf1_reads", reads, 28);
        check("rf1_run", maxrun, 28);
        check("rf1_addr", 32'(rom_addr), 196);
        check("rf1_ready", 32'(ib_ready), 1);
        check_heads("rf1");

        run_fetch(200, -1, -1, 0, -1, -1, -1, '0, reads, maxrun);
        model_rows(1);
        check("rf2_reads", reads, 28);
        check("rf2_addr", 32'(rom_addr), 224);
        check_heads("rf2");

        // Pulses during a refill queue exactly one more refill
        run_fetch(300, -1, -1, 0, 5, 9, -1, '0, reads, maxrun);
        model_rows(2);
        check("pend_reads", reads, 56);
        check("pend_run", maxrun, 28);
        check("pend_addr", 32'(rom_addr), 280);
        check("pend_rd_en", 32'(rom_rd_en), 0);
        check_heads("pend");

        // Randomized image reloaded from READY, drained and refilled to the last row
        wr = $urandom_range(8, 32);
        kr = $urandom_range(1, 6);
        cfg_w = 32'(wr); cfg_k = 4'(kr);
        model_start(wr, kr);
        run_fetch(1000, 0, -1, -1, -1, -1, -1, '0, reads, maxrun);
        check("rnd_pf_reads", reads, (kr+1)*wr);
        check("rnd_pf_addr", 32'(rom_addr), 32'(m_addr));
        check("rnd_pf_ready", 32'(ib_ready), 1);
        check_heads("rnd_pf");
        while (m_rows < m_w) begin
            pop_cols({$urandom, $urandom}, "rnd_pop");
            full = 0;
            for (int c = 0; c < BW; c++) if (exp_q[c].size() >= FD) full = 1;
            if (full) pop_cols('1, "rnd_drain");
            nm = '0;
            for (int c = 0; c < BW; c++) nm[c] = (exp_q[c].size() > 0);
            pm = {$urandom, $urandom} & nm;
            pp = $urandom_range(1, m_w);
            run_fetch(200, -1, -1, 0, -1, -1, pp, pm, reads, maxrun);
            model_pop(pm);
            model_rows(1);
            check("rnd_rf_reads", reads, m_w);
            check("rnd_rf_addr", 32'(rom_addr), 32'(m_addr));
            check_heads("rnd_rf");
        end
        run_fetch(30, -1, -1, 0, -1, -1, -1, '0, reads, maxrun);
        check("done_reads", reads, 0);
        check("done_addr", 32'(rom_addr), 32'(m_addr));

        // Reset in the middle of a prefetch, then a clean reload
        cfg_w = 28; cfg_k = 5;
        run_fetch(60, 0, -1, -1, -1, -1, -1, '0, reads, maxrun);
        check("mid_reads", reads, 60);
        #2 rst = 1'b1;
        #1;
        model_clear();
        check("mrst_addr", 32'(rom_addr), 0);
        check("mrst_rd_en", 32'(rom_rd_en), 0);
        check("mrst_ready", 32'(ib_ready), 0);
        check("mrst_state", 32'(dbg_state), 0);
        check_heads("mrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_start(28, 5);
        run_fetch(1000, 0, -1, -1, -1, -1, -1, '0, reads, maxrun);
        check("re_reads", reads, 168);
        check("re_addr", 32'(rom_addr), 168);
        check("re_ready", 32'(ib_ready), 1);
        check_heads("re");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
